// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED pattern scheduler: mode codes, FSM states,
// blink phase bit indices and the mode-to-drive decoder.
package led_sched_pkg;

  localparam logic [2:0] MODE_NONE       = 3'b000;
  localparam logic [2:0] MODE_GREEN      = 3'b001;
  localparam logic [2:0] MODE_RED        = 3'b010;
  localparam logic [2:0] MODE_AMBER      = 3'b011;
  localparam logic [2:0] MODE_RSVD       = 3'b100;
  localparam logic [2:0] MODE_GREEN_SLOW = 3'b101;
  localparam logic [2:0] MODE_RED_SLOW   = 3'b110;
  localparam logic [2:0] MODE_RED_FAST   = 3'b111;

  localparam int unsigned SLOW_BIT = 5;
  localparam int unsigned FAST_BIT = 3;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_LT_RED   = 2'd1,
    ST_LT_GREEN = 2'd2,
    ST_RUN      = 2'd3
  } led_state_t;

  typedef struct packed {
    logic red;
    logic green;
  } led_drive_t;

  // The reserved code behaves exactly like "none".
  function automatic logic mode_is_none(input logic [2:0] mode);
    return (mode == MODE_NONE) || (mode == MODE_RSVD);
  endfunction

  function automatic led_drive_t mode_drive(input logic [2:0] mode,
                                            input logic [5:0] blink);
    led_drive_t d;
    d = '0;
    case (mode)
      MODE_GREEN:      d.green = 1'b1;
      MODE_RED:        d.red   = 1'b1;
      MODE_AMBER:      begin d.red = 1'b1; d.green = 1'b1; end
      MODE_GREEN_SLOW: d.green = blink[SLOW_BIT];
      MODE_RED_SLOW:   d.red   = blink[SLOW_BIT];
      MODE_RED_FAST:   d.red   = blink[FAST_BIT];
      default:         d       = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/led_locate_timer.sv
// Per-channel locate timer: load on start, clear on stop (stop wins),
// decrement on Strobe16ms while nonzero.
module led_locate_timer #(
  parameter int unsigned LOCATE_TICKS = 1875
) (
  input  logic SlowClock,
  input  logic Reset,
  input  logic Strobe16ms,
  input  logic LocateStart,
  input  logic LocateStop,
  output logic LocateActive
);

  localparam int unsigned TW = $clog2(LOCATE_TICKS + 1);

  logic [TW-1:0] timer;

  always_ff @(posedge SlowClock) begin
    if (Reset)
      timer <= '0;
    else if (LocateStop)
      timer <= '0;
    else if (LocateStart)
      timer <= TW'(LOCATE_TICKS);
    else if (Strobe16ms && (timer != '0))
      timer <= timer - 1'b1;
  end

  assign LocateActive = (timer != '0);

endmodule

// File: rtl/led_pattern_sched.sv
// Bicolor LED arbiter (Locate > Fault > Status) with blink generation and an
// optional power-on lamp test enabled by LED_LAMP_TEST_EN.
module led_pattern_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_LED      = 4,
  parameter int unsigned LOCATE_TICKS = 1875,
  parameter int unsigned LT_TICKS     = 32
) (
  input  logic                   SlowClock,
  input  logic                   Reset,
  input  logic                   Strobe16ms,
  input  logic                   PwrOn,
  input  logic [3*NUM_LED-1:0]   StatusReq,
  input  logic [3*NUM_LED-1:0]   FaultReq,
  input  logic [NUM_LED-1:0]     LocateStart,
  input  logic [NUM_LED-1:0]     LocateStop,
  output logic [NUM_LED-1:0]     LocateActive,
  output logic [NUM_LED-1:0]     LedG_N,
  output logic [NUM_LED-1:0]     LedR_N,
  output logic                   LampTestBusy
);

  if (LT_TICKS == 0) begin : g_bad_lt_ticks
    $error("led_pattern_sched: LT_TICKS must be nonzero");
  end

  led_state_t           state, state_next;
  logic [5:0]           blink_cnt;
  logic [NUM_LED-1:0]   g_on, r_on;

  for (genvar i = 0; i < NUM_LED; i++) begin : g_locate
    led_locate_timer #(
      .LOCATE_TICKS (LOCATE_TICKS)
    ) u_timer (
      .SlowClock    (SlowClock),
      .Reset        (Reset),
      .Strobe16ms   (Strobe16ms),
      .LocateStart  (LocateStart[i]),
      .LocateStop   (LocateStop[i]),
      .LocateActive (LocateActive[i])
    );
  end

  always_ff @(posedge SlowClock) begin
    if (Reset)
      blink_cnt <= '0;
    else if (Strobe16ms)
      blink_cnt <= blink_cnt + 6'd1;
  end

`ifdef LED_LAMP_TEST_EN
  localparam int unsigned PW = (LT_TICKS > 1) ? $clog2(LT_TICKS) : 1;

  logic [PW-1:0] phase_cnt;
  logic          phase_done;

  assign phase_done = Strobe16ms && (phase_cnt == PW'(LT_TICKS - 1));

  // Any state change clears the count, so each phase starts from zero.
  always_ff @(posedge SlowClock) begin
    if (Reset)
      phase_cnt <= '0;
    else if (state_next != state)
      phase_cnt <= '0;
    else if (Strobe16ms && ((state == ST_LT_RED) || (state == ST_LT_GREEN)))
      phase_cnt <= phase_cnt + 1'b1;
  end

  assign LampTestBusy = (state == ST_LT_RED) || (state == ST_LT_GREEN);
`else
  assign LampTestBusy = 1'b0;
`endif

  always_ff @(posedge SlowClock) begin
    if (Reset)
      state <= ST_OFF;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef LED_LAMP_TEST_EN
      ST_OFF:      if (PwrOn) state_next = ST_LT_RED;
      ST_LT_RED:   if (phase_done) state_next = ST_LT_GREEN;
      ST_LT_GREEN: if (phase_done) state_next = ST_RUN;
`else
      ST_OFF:      if (PwrOn) state_next = ST_RUN;
`endif
      ST_RUN:      state_next = ST_RUN;
      default:     state_next = ST_OFF;
    endcase
    if (!PwrOn)
      state_next = ST_OFF;
  end

  // PwrOn gates the drive directly so the LEDs go dark on the same edge
  // that takes the FSM to OFF.
  always_comb begin
    g_on = '0;
    r_on = '0;
    if (PwrOn) begin
      case (state)
`ifdef LED_LAMP_TEST_EN
        ST_LT_RED:   r_on = '1;
        ST_LT_GREEN: g_on = '1;
`endif
        ST_RUN: begin
          for (int unsigned i = 0; i < NUM_LED; i++) begin
            if (LocateActive[i]) begin
              g_on[i] = blink_cnt[FAST_BIT];
              r_on[i] = 1'b0;
            end else if (!mode_is_none(FaultReq[3*i +: 3])) begin
              {r_on[i], g_on[i]} = mode_drive(FaultReq[3*i +: 3], blink_cnt);
            end else begin
              {r_on[i], g_on[i]} = mode_drive(StatusReq[3*i +: 3], blink_cnt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SlowClock) begin
    if (Reset) begin
      LedG_N <= '1;
      LedR_N <= '1;
    end else begin
      LedG_N <= ~g_on;
      LedR_N <= ~r_on;
    end
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched; lamp-test checks are built only when
// LED_LAMP_TEST_EN is defined, otherwise the direct OFF->RUN path is checked.
module tb_led_pattern_sched;

  localparam int unsigned NUM_LED      = 4;
  localparam int unsigned LOCATE_TICKS = 4;
  localparam int unsigned LT_TICKS     = 4;

  logic                 SlowClock  = 1'b0;
  logic                 Reset      = 1'b1;
  logic                 Strobe16ms = 1'b0;
  logic                 PwrOn      = 1'b0;
  logic [3*NUM_LED-1:0] StatusReq  = '0;
  logic [3*NUM_LED-1:0] FaultReq   = '0;
  logic [NUM_LED-1:0]   LocateStart = '0;
  logic [NUM_LED-1:0]   LocateStop  = '0;
  logic [NUM_LED-1:0]   LocateActive, LedG_N, LedR_N;
  logic                 LampTestBusy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [5:0]  bc       = '0;   // expected BlinkCnt

  led_pattern_sched #(
    .NUM_LED      (NUM_LED),
    .LOCATE_TICKS (LOCATE_TICKS),
    .LT_TICKS     (LT_TICKS)
  ) dut (
    .SlowClock    (SlowClock),
    .Reset        (Reset),
    .Strobe16ms   (Strobe16ms),
    .PwrOn        (PwrOn),
    .StatusReq    (StatusReq),
    .FaultReq     (FaultReq),
    .LocateStart  (LocateStart),
    .LocateStop   (LocateStop),
    .LocateActive (LocateActive),
    .LedG_N       (LedG_N),
    .LedR_N       (LedR_N),
    .LampTestBusy (LampTestBusy)
  );

  always #5 SlowClock = ~SlowClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock edge; inputs are applied and outputs observed at negedges.
  task automatic tick(input logic stb);
    Strobe16ms = stb;
    @(negedge SlowClock);
    if (stb && !Reset) bc = bc + 6'd1;
    Strobe16ms  = 1'b0;
    LocateStart = '0;
    LocateStop  = '0;
  endtask

`ifdef LED_LAMP_TEST_EN
  // Called with the FSM just entered LT_RED; returns with the FSM in RUN.
  task automatic run_lamp_test(input string tag);
    int unsigned busy_strobes;
    busy_strobes = 0;
    tick(1'b0);
    check({tag, "_red_r"}, LedR_N, 4'h0);
    check({tag, "_red_g"}, LedG_N, 4'hF);
    for (int unsigned k = 0; k < 2 * LT_TICKS; k++) begin
      if (LampTestBusy) busy_strobes++;
      tick(1'b1);
      if (k == LT_TICKS - 1) begin
        tick(1'b0);
        check({tag, "_green_g"}, LedG_N, 4'h0);
        check({tag, "_green_r"}, LedR_N, 4'hF);
      end
    end
    check({tag, "_busy_strobes"}, busy_strobes, 2 * LT_TICKS);
    check({tag, "_done_busy"}, LampTestBusy, 1'b0);
  endtask
`endif

  initial begin
    // Reset with power on: everything dark
    PwrOn = 1'b1;
    StatusReq[11:9] = 3'b001;
    repeat (3) tick(1'b0);
    check("rst_g", LedG_N, 4'hF);
    check("rst_r", LedR_N, 4'hF);
    check("rst_locate", LocateActive, 4'h0);
    check("rst_busy", LampTestBusy, 1'b0);

    Reset = 1'b0;
    tick(1'b0);
    check("pwr_edge_g", LedG_N, 4'hF);
    check("pwr_edge_r", LedR_N, 4'hF);
`ifdef LED_LAMP_TEST_EN
    check("lt_entry_busy", LampTestBusy, 1'b1);
    run_lamp_test("lt");
`else
    check("busy_tied0", LampTestBusy, 1'b0);
`endif
    tick(1'b0);
    check("run_status_g", LedG_N, 4'b0111);
    check("run_status_r", LedR_N, 4'hF);
    check("run_busy", LampTestBusy, 1'b0);

    // Fault red slow blink overrides status green on ch0
    StatusReq[2:0] = 3'b001;
    FaultReq[2:0]  = 3'b110;
    tick(1'b0);
    check("fault_slow_start", {LedG_N[0], LedR_N[0]}, {1'b1, ~bc[5]});
    for (int unsigned k = 0; k < 40; k++) begin
      tick(1'b1);
      tick(1'b0);
      check("fault_slow_blink", {LedG_N[0], LedR_N[0]}, {1'b1, ~bc[5]});
    end
    FaultReq[2:0] = 3'b000;
    tick(1'b0);
    check("fault_clear_green", {LedG_N[0], LedR_N[0]}, 2'b01);

    // Locate on ch1 overrides a solid red fault; start coincides with a strobe
    FaultReq[5:3] = 3'b010;
    tick(1'b0);
    check("ch1_fault_red", {LedG_N[1], LedR_N[1]}, 2'b10);
    LocateStart[1] = 1'b1;
    tick(1'b1);
    check("loc1_active", LocateActive, 4'b0010);
    check("loc1_first_edge", {LedG_N[1], LedR_N[1]}, 2'b10);
    for (int unsigned k = 0; k < LOCATE_TICKS; k++) begin
      tick(1'b1);
      check("loc1_count", LocateActive[1], (k < LOCATE_TICKS - 1) ? 1'b1 : 1'b0);
      tick(1'b0);
      if (k < LOCATE_TICKS - 1)
        check("loc1_fast", {LedG_N[1], LedR_N[1]}, {~bc[3], 1'b1});
      else
        check("loc1_fault_back", {LedG_N[1], LedR_N[1]}, 2'b10);
    end

    // ch2: stop wins, restart reloads, stop cancels
    LocateStart[2] = 1'b1;
    LocateStop[2]  = 1'b1;
    tick(1'b0);
    check("loc2_stop_wins", LocateActive[2], 1'b0);
    LocateStart[2] = 1'b1;
    tick(1'b0);
    check("loc2_start", LocateActive[2], 1'b1);
    repeat (2) tick(1'b1);
    LocateStart[2] = 1'b1;
    tick(1'b0);
    repeat (LOCATE_TICKS - 1) tick(1'b1);
    check("loc2_reload_held", LocateActive[2], 1'b1);
    tick(1'b1);
    check("loc2_reload_expire", LocateActive[2], 1'b0);
    LocateStart[2] = 1'b1;
    tick(1'b1);
    LocateStop[2] = 1'b1;
    tick(1'b0);
    check("loc2_stop", LocateActive[2], 1'b0);

    // Mode codes on ch3 (status only), plus reserved fault falling through
    StatusReq[11:9] = 3'b011;
    tick(1'b0);
    check("mode_amber", {LedG_N[3], LedR_N[3]}, 2'b00);
    StatusReq[11:9] = 3'b100;
    tick(1'b0);
    check("mode_rsvd_off", {LedG_N[3], LedR_N[3]}, 2'b11);
    StatusReq[11:9] = 3'b101;
    tick(1'b0);
    check("mode_green_slow", {LedG_N[3], LedR_N[3]}, {~bc[5], 1'b1});
    StatusReq[11:9] = 3'b111;
    for (int unsigned k = 0; k < 16; k++) begin
      tick(1'b1);
      tick(1'b0);
      check("mode_red_fast", {LedG_N[3], LedR_N[3]}, {1'b1, ~bc[3]});
    end
    StatusReq[11:9] = 3'b001;
    FaultReq[11:9]  = 3'b100;
    tick(1'b0);
    check("fault_rsvd_passthru", {LedG_N[3], LedR_N[3]}, 2'b01);
    FaultReq[11:9] = 3'b000;

    // Power drop: outputs dark next edge, locate timer keeps its state
    FaultReq[5:3]  = 3'b000;
    LocateStart[1] = 1'b1;
    tick(1'b0);
    PwrOn = 1'b0;
    tick(1'b0);
    check("pwroff_g", LedG_N, 4'hF);
    check("pwroff_r", LedR_N, 4'hF);
    check("pwroff_busy", LampTestBusy, 1'b0);
    check("pwroff_locate_kept", LocateActive[1], 1'b1);
    PwrOn = 1'b1;
    tick(1'b0);
    check("repwr_edge_g", LedG_N, 4'hF);
`ifdef LED_LAMP_TEST_EN
    check("repwr_busy", LampTestBusy, 1'b1);
    tick(1'b0);
    check("repwr_red", LedR_N, 4'h0);
    repeat (LT_TICKS) tick(1'b1);
    tick(1'b0);
    check("drop_pre_green", LedG_N, 4'h0);
    PwrOn = 1'b0;
    tick(1'b0);
    check("drop_lt_green_g", LedG_N, 4'hF);
    check("drop_lt_green_r", LedR_N, 4'hF);
    check("drop_lt_green_busy", LampTestBusy, 1'b0);
    PwrOn = 1'b1;
    tick(1'b0);
    check("restart_busy", LampTestBusy, 1'b1);
    run_lamp_test("lt2");
`else
    tick(1'b0);
    check("repwr_run_g", LedG_N, {1'b0, 1'b1, ~bc[3], 1'b0});
    check("repwr_run_r", LedR_N, 4'hF);
    check("repwr_busy0", LampTestBusy, 1'b0);
`endif

    // Reset while running
    Reset = 1'b1;
    tick(1'b0);
    check("rst2_g", LedG_N, 4'hF);
    check("rst2_r", LedR_N, 4'hF);
    check("rst2_locate", LocateActive, 4'h0);
    check("rst2_busy", LampTestBusy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_sched.md
# led_pattern_sched

Per-channel bicolor LED controller that arbitrates LED requests from three requesters: Locate (BMC identify), Fault and Status. It generates solid and blink patterns from the 16 ms strobe and runs a power-on lamp-test sequence. It sits between the status/register logic and the board LED pins, alongside the existing system, PSU and fan LED drivers. Outputs are registered, active-low, and forced off while the power switch is off.

## Interface
Parameters:
- NUM_LED, 4: number of bicolor LED channels.
- LOCATE_TICKS, 1875: locate duration in Strobe16ms ticks (1875 = 30 s).
- LT_TICKS, 32: Strobe16ms ticks per lamp-test phase.

Ports:
- SlowClock  in  1  32,768 Hz oscillator clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- Strobe16ms  in  1  single-SlowClock pulse every 16 ms.
- PwrOn  in  1  1 = power switch on (FM_PS_EN decoded).
- StatusReq  in  3*NUM_LED  per-channel mode code, lowest priority.
- FaultReq  in  3*NUM_LED  per-channel mode code, middle priority.
- LocateStart  in  NUM_LED  one-cycle pulse: start or restart locate on a channel.
- LocateStop  in  NUM_LED  one-cycle pulse: cancel locate on a channel.
- LocateActive  out  NUM_LED  locate timer running.
- LedG_N  out  NUM_LED  green drive, active-low.
- LedR_N  out  NUM_LED  red drive, active-low.
- LampTestBusy  out  1  lamp test in progress.

## Operation
Mode codes (3 bits per channel):
- 000 none, 001 green, 010 red, 011 amber (both colours on).
- 101 green slow blink, 110 red slow blink, 111 red fast blink.
- 100 is reserved and decodes as none.

Blink timing:
- BlinkCnt is a 6-bit free-running counter that increments on Strobe16ms and wraps 63→0.
- Slow phase = BlinkCnt[5]: 512 ms on / 512 ms off.
- Fast phase = BlinkCnt[3]: 128 ms on / 128 ms off.
- "On" means the phase bit is 1.

Arbitration, per channel, in RUN state:
- Locate active → green fast blink.
- Else FaultReq if it is not none.
- Else StatusReq.
- Else both LEDs off.

Locate timer, per channel:
- LocateStart loads LOCATE_TICKS. A start while already active reloads the timer.
- The timer decrements on Strobe16ms while nonzero.
- LocateActive = (timer != 0).
- LocateStop clears the timer to 0. LocateStop wins over a simultaneous LocateStart.

Top-level FSM:
- States: OFF, LT_RED, LT_GREEN, RUN.
- OFF: when PwrOn = 1, go to LT_RED and clear PhaseCnt.
- LT_RED: all red on, green off. After LT_TICKS strobes, go to LT_GREEN and clear PhaseCnt.
- LT_GREEN: all green on, red off. After LT_TICKS strobes, go to RUN.
- RUN: arbitrated patterns are driven.
- PwrOn = 0 in any state → OFF on the next edge. In OFF all outputs are 1.
- LampTestBusy = 1 in LT_RED and LT_GREEN.
- Locate timers keep running in every state. In non-RUN states they are only masked at the outputs.

## Timing
Reset values:
- Reset takes priority over all other inputs.
- State = OFF, BlinkCnt = 0, PhaseCnt = 0, all locate timers = 0.
- LedG_N = LedR_N = all 1s, LocateActive = 0, LampTestBusy = 0.

Latencies:
- Request change in RUN → output change 1 SlowClock cycle later (registered outputs).
- LocateStart at edge n → LocateActive = 1 after edge n.
- PwrOn rise at edge n → state LT_RED after edge n; red LEDs on after edge n+1.

Strobe handling:
- A Strobe16ms that coincides with a LocateStart does not decrement the newly loaded value.
- Lamp-test phase length is exactly LT_TICKS strobes, counted from the first strobe after phase entry.
- LT_TICKS = 0 is illegal.

Widths:
- Locate timer width is $clog2(LOCATE_TICKS+1).
- Decrement saturates at 0.

## Configuration
- LED_LAMP_TEST_EN defined: OFF→LT_RED→LT_GREEN→RUN as above.
- LED_LAMP_TEST_EN undefined:
  - OFF goes directly to RUN when PwrOn = 1.
  - LT states and PhaseCnt are not built.
  - LampTestBusy is tied to 0.

## Structure
- Shared package/include `led_sched_pkg`:
  - Mode code constants (MODE_NONE … MODE_RED_FAST).
  - FSM state encodings.
  - Blink bit indices (SLOW_BIT = 5, FAST_BIT = 3).
- One sub-module, `led_locate_timer`, instantiated NUM_LED times. It contains the load/stop/decrement counter and the active flag.

## Test plan
- Reset with PwrOn = 1 and the macro defined → outputs all 1. After reset release: 32 strobes red only, 32 strobes green only, then RUN; LampTestBusy high for exactly 64 strobes.
- RUN, StatusReq ch0 = 001, FaultReq ch0 = 110 → ch0 red toggles every 32 strobes with green off. Set FaultReq ch0 = 000 → ch0 solid green 1 cycle later.
- LocateStart ch1 with LOCATE_TICKS = 4 → green fast blink overrides a red Fault. LocateActive drops after the 4th strobe, then the Fault pattern returns.
- LocateStart and LocateStop asserted together on ch2 → LocateActive stays 0. LocateStart mid-count → timer reloads to LOCATE_TICKS.
- PwrOn dropped during LT_GREEN → all outputs 1 next cycle, state OFF. PwrOn re-raised → lamp test restarts from LT_RED.
- Macro undefined → PwrOn rise goes straight to RUN with LampTestBusy constant 0. Mode 100 drives the channel off.
